// File: rtl/tcm_boot_loader_if.sv
// rtl/tcm_boot_loader_if.sv - Image byte stream and TCM write-port bundle for the boot loader
// Purpose: carries the boot image byte stream into the loader and the loader's
// word writes out to the TCM data port.
// Signals:
//   load_start_i           image source -> loader  one-cycle start pulse
//   load_data_i[7:0]       image source -> loader  image byte, little-endian
//   load_valid_i           image source -> loader  load_data_i is valid
//   load_ready_o           loader -> image source  byte taken this cycle
//   mem_d_addr_o[31:0]     loader -> TCM           write byte address
//   mem_d_data_wr_o[31:0]  loader -> TCM           write data
//   mem_d_wr_o[3:0]        loader -> TCM           byte write strobes
//   mem_d_rd_o             loader -> TCM           read request (unused, 0)
//   mem_d_req_tag_o[10:0]  loader -> TCM           request tag
//   mem_d_accept_i         TCM -> loader           request accepted
//   mem_d_ack_i            TCM -> loader           write completion
//   mem_d_error_i          TCM -> loader           completion error
// modport master: the loader.  modport slave: image source and TCM.
interface tcm_boot_loader_if;
   logic        load_start_i;
   logic [7:0]  load_data_i;
   logic        load_valid_i;
   logic        load_ready_o;
   logic [31:0] mem_d_addr_o;
   logic [31:0] mem_d_data_wr_o;
   logic [3:0]  mem_d_wr_o;
   logic        mem_d_rd_o;
   logic [10:0] mem_d_req_tag_o;
   logic        mem_d_accept_i;
   logic        mem_d_ack_i;
   logic        mem_d_error_i;

   modport master (
      input  load_start_i, load_data_i, load_valid_i,
      output load_ready_o,
      output mem_d_addr_o, mem_d_data_wr_o, mem_d_wr_o, mem_d_rd_o, mem_d_req_tag_o,
      input  mem_d_accept_i, mem_d_ack_i, mem_d_error_i
   );

   modport slave (
      output load_start_i, load_data_i, load_valid_i,
      input  load_ready_o,
      input  mem_d_addr_o, mem_d_data_wr_o, mem_d_wr_o, mem_d_rd_o, mem_d_req_tag_o,
      output mem_d_accept_i, mem_d_ack_i, mem_d_error_i
   );
endinterface

// File: rtl/tcm_boot_loader.sv
// rtl/tcm_boot_loader.sv - Loads a byte-stream boot image into TCM, then releases the core reset
// Purpose: packs incoming bytes little-endian into 32-bit words, writes each word
// to TCM at BASE_ADDR + 4*index and waits for its completion, then deasserts
// cpu_rst_o once the whole image is written. A write error parks the block in
// ERROR with the core held in reset.
// Ports:
//   clk_i       in   core/TCM clock
//   rst_i       in   asynchronous active-low reset (release synchronised to clk_i)
//   bus         --   tcm_boot_loader_if.master: byte stream in, TCM write port out
//   cpu_rst_o   out  active-high core reset, low only once the image is loaded
//   busy_o      out  load in progress
//   done_o      out  image fully written
//   error_o     out  a write completed with error
module tcm_boot_loader #(
   parameter int unsigned IMAGE_WORDS = 32768,
   parameter logic [31:0] BASE_ADDR   = 32'h00000000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   tcm_boot_loader_if.master bus,
   output logic              cpu_rst_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o
);
   localparam int IDX_W = $clog2(IMAGE_WORDS) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMAGE_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      WRITE,
      WAIT_ACK,
      DONE,
      ERROR
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [1:0]       byte_q, byte_d;
   logic [31:0]      word_q, word_d;
   logic [1:0]       rst_sync_q;
   logic             rst_n_int;
   logic             complete;
   logic [31:0]      idx_ext;

   // Assertion reaches the FSM immediately; release is retimed through two flops.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n_int = rst_sync_q[1];

   always_ff @(posedge clk_i or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state_q <= IDLE;
         idx_q   <= '0;
         byte_q  <= 2'd0;
         word_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         byte_q  <= byte_d;
         word_q  <= word_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      byte_d   = byte_q;
      word_d   = word_q;
      complete = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.load_start_i) begin
               state_d = COLLECT;
               idx_d   = '0;
               byte_d  = 2'd0;
               word_d  = 32'h0;
            end
         end
         COLLECT: begin
            // load_ready_o is 1 throughout COLLECT, so valid alone is the handshake.
            if (bus.load_valid_i) begin
               word_d[{byte_q, 3'b000} +: 8] = bus.load_data_i;
               byte_d = byte_q + 2'd1;
               if (byte_q == 2'd3) begin
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            if (bus.mem_d_accept_i) begin
               state_d  = WAIT_ACK;
               // An ack riding on the accept cycle finishes the word right away.
               complete = bus.mem_d_ack_i;
            end
         end
         WAIT_ACK: begin
            complete = bus.mem_d_ack_i;
         end
         default: begin
         end
      endcase

      if (complete) begin
         if (bus.mem_d_error_i) begin
            state_d = ERROR;
         end else if (idx_q == LAST_IDX) begin
            state_d = DONE;
         end else begin
            idx_d   = idx_q + 1'b1;
            state_d = COLLECT;
         end
      end
   end

   assign idx_ext = 32'(idx_q);

   // Address, data and tag are zero outside WRITE so the bus is quiet in reset and idle.
   always_comb begin
      bus.load_ready_o    = (state_q == COLLECT);
      bus.mem_d_wr_o      = 4'h0;
      bus.mem_d_addr_o    = 32'h0;
      bus.mem_d_data_wr_o = 32'h0;
      bus.mem_d_req_tag_o = 11'h0;
      if (state_q == WRITE) begin
         bus.mem_d_wr_o      = 4'hF;
         bus.mem_d_addr_o    = BASE_ADDR + (idx_ext << 2);
         bus.mem_d_data_wr_o = word_q;
         bus.mem_d_req_tag_o = idx_ext[10:0];
      end
   end

   assign bus.mem_d_rd_o = 1'b0;

   assign cpu_rst_o = (state_q != DONE);
   assign busy_o    = (state_q == COLLECT) || (state_q == WRITE) || (state_q == WAIT_ACK);
   assign done_o    = (state_q == DONE);
   assign error_o   = (state_q == ERROR);
endmodule

// File: tb/tb_tcm_boot_loader.sv
// tb/tb_tcm_boot_loader.sv - Scoreboard bench for tcm_boot_loader with random image bytes and TCM timing
module tb_tcm_boot_loader;
   localparam int unsigned WORDS = 4;
   localparam logic [31:0] BASE  = 32'h0000_2000;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [10:0] tag;
   } wr_t;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   logic cpu_rst_o, busy_o, done_o, error_o;

   tcm_boot_loader_if bus();

   tcm_boot_loader #(.IMAGE_WORDS(WORDS), .BASE_ADDR(BASE)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .bus      (bus),
      .cpu_rst_o(cpu_rst_o),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .error_o  (error_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_bad = 0;
   wr_t exp_q[$];

   // responder / monitor shared state
   int acc_wait = 0;
   int ack_wait = 0;
   bit in_flight = 0;
   bit err_pend = 0;
   bit legit_ack = 0;
   bit same_cycle = 0;
   bit stray_en = 0;
   int err_at = -1;
   int wr_seen = 0;
   int comps = 0;
   int exp_total = 0;
   bit expect_err = 0;
   bit chk_next = 0;
   int held_cnt = 0;
   int n_writes = 0;
   int first_hold = 0;
   logic [31:0] prev_addr, prev_data;
   logic [3:0]  prev_wr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
      end
   endtask

   // TCM model: random accept latency, random or same-cycle ack, error on word err_at,
   // optional stray acks while no request is outstanding.
   initial begin
      bus.mem_d_accept_i = 1'b0;
      bus.mem_d_ack_i    = 1'b0;
      bus.mem_d_error_i  = 1'b0;
      forever begin
         @(posedge clk_i);
         #1;
         bus.mem_d_accept_i = 1'b0;
         bus.mem_d_ack_i    = 1'b0;
         bus.mem_d_error_i  = 1'b0;
         legit_ack          = 1'b0;
         if (!rst_i) begin
            in_flight = 1'b0;
            acc_wait  = 0;
         end else if (in_flight) begin
            if (ack_wait == 0) begin
               bus.mem_d_ack_i   = 1'b1;
               bus.mem_d_error_i = err_pend;
               legit_ack         = 1'b1;
               in_flight         = 1'b0;
            end else begin
               ack_wait--;
            end
         end else if (bus.mem_d_wr_o != 4'h0) begin
            if (acc_wait == 0) begin
               bus.mem_d_accept_i = 1'b1;
               err_pend = (wr_seen == err_at);
               wr_seen++;
               ack_wait = same_cycle ? 0 : $urandom_range(0, 3);
               if (ack_wait == 0) begin
                  bus.mem_d_ack_i   = 1'b1;
                  bus.mem_d_error_i = err_pend;
                  legit_ack         = 1'b1;
               end else begin
                  in_flight = 1'b1;
                  ack_wait--;
               end
               acc_wait = same_cycle ? 0 : $urandom_range(0, 3);
            end else begin
               acc_wait--;
            end
         end else if (stray_en && $urandom_range(0, 5) == 0) begin
            bus.mem_d_ack_i   = 1'b1;
            bus.mem_d_error_i = 1'($urandom_range(0, 1));
         end
      end
   end

   // Monitor: pops the scoreboard on every accepted write and checks request stability.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk_i);
         if (rst_i && bus.mem_d_wr_o != 4'h0) begin
            chk("wr_strobe", {28'h0, bus.mem_d_wr_o}, 32'hF);
            if (held_cnt > 0) begin
               chk("hold_addr", bus.mem_d_addr_o, prev_addr);
               chk("hold_data", bus.mem_d_data_wr_o, prev_data);
               chk("hold_wr", {28'h0, bus.mem_d_wr_o}, {28'h0, prev_wr});
            end
            if (bus.mem_d_accept_i) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_write: got addr %h data %h, required no write", bus.mem_d_addr_o, bus.mem_d_data_wr_o);
               end else begin
                  e = exp_q.pop_front();
                  chk("wr_addr", bus.mem_d_addr_o, e.addr);
                  chk("wr_data", bus.mem_d_data_wr_o, e.data);
                  chk("wr_tag", {21'h0, bus.mem_d_req_tag_o}, {21'h0, e.tag});
               end
               if (n_writes == 0) first_hold = held_cnt;
               n_writes++;
               held_cnt = 0;
            end else begin
               held_cnt++;
               prev_addr = bus.mem_d_addr_o;
               prev_data = bus.mem_d_data_wr_o;
               prev_wr   = bus.mem_d_wr_o;
            end
         end else begin
            held_cnt = 0;
         end
         if (chk_next) begin
            chk("cpu_rst_after_last", {31'h0, cpu_rst_o}, 32'h0);
            chk("done_after_last", {31'h0, done_o}, 32'h1);
            chk_next = 1'b0;
         end
         if (legit_ack) begin
            comps++;
            if (!expect_err && comps == exp_total) begin
               chk("cpu_rst_at_last_ack", {31'h0, cpu_rst_o}, 32'h1);
               chk_next = 1'b1;
            end
         end
      end
   end

   task automatic reset_checks();
      chk("rst_cpu_rst", {31'h0, cpu_rst_o}, 32'h1);
      chk("rst_ready", {31'h0, bus.load_ready_o}, 32'h0);
      chk("rst_wr", {28'h0, bus.mem_d_wr_o}, 32'h0);
      chk("rst_rd", {31'h0, bus.mem_d_rd_o}, 32'h0);
      chk("rst_addr", bus.mem_d_addr_o, 32'h0);
      chk("rst_data", bus.mem_d_data_wr_o, 32'h0);
      chk("rst_tag", {21'h0, bus.mem_d_req_tag_o}, 32'h0);
      chk("rst_status", {29'h0, busy_o, done_o, error_o}, 32'h0);
   endtask

   task automatic do_reset();
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      #1;
      reset_checks();
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
   endtask

   task automatic pulse_start();
      @(posedge clk_i);
      #1;
      bus.load_start_i = 1'b1;
      @(posedge clk_i);
      #1;
      bus.load_start_i = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t;
      repeat ($urandom_range(0, 2)) begin
         @(posedge clk_i);
         #1;
      end
      bus.load_valid_i = 1'b1;
      bus.load_data_i  = b;
      t = 0;
      @(negedge clk_i);
      while (!bus.load_ready_o && t < 100) begin
         @(negedge clk_i);
         t++;
      end
      if (t >= 100) begin
         n_cmp++;
         n_bad++;
         $display("FAIL byte_timeout: got load_ready_o 0 for 100 cycles, required 1");
      end
      @(posedge clk_i);
      #1;
      bus.load_valid_i = 1'b0;
      bus.load_data_i  = 8'($urandom);
   endtask

   task automatic run_load(input int err_word, input bit sc, input bit hold5, input bit mid_start);
      logic [7:0] img[WORDS*4];
      int t;
      int rdy_seen;
      for (int i = 0; i < int'(WORDS * 4); i++) img[i] = 8'($urandom);
      same_cycle = sc;
      err_at     = err_word;
      wr_seen    = 0;
      comps      = 0;
      n_writes   = 0;
      first_hold = 0;
      expect_err = (err_word >= 0);
      exp_total  = expect_err ? err_word + 1 : int'(WORDS);
      for (int w = 0; w < exp_total; w++) begin
         exp_q.push_back('{BASE + 32'(4 * w),
                           {img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]},
                           11'(w)});
      end
      acc_wait = hold5 ? 5 : 0;
      pulse_start();
      for (int i = 0; i < 4 * exp_total; i++) begin
         if (mid_start && i == 5) pulse_start();
         send_byte(img[i]);
      end
      t = 0;
      @(negedge clk_i);
      while (!done_o && !error_o && t < 300) begin
         @(negedge clk_i);
         t++;
      end
      repeat (2) @(negedge clk_i);
      chk("end_done", {31'h0, done_o}, {31'h0, !expect_err});
      chk("end_error", {31'h0, error_o}, {31'h0, expect_err});
      chk("end_cpu_rst", {31'h0, cpu_rst_o}, {31'h0, expect_err});
      chk("end_busy", {31'h0, busy_o}, 32'h0);
      chk("end_ready", {31'h0, bus.load_ready_o}, 32'h0);
      chk("queue_drained", exp_q.size(), 32'h0);
      if (hold5) chk("accept_hold_cycles", first_hold, 32'd5);
      if (expect_err) begin
         // Keep offering bytes: none may be taken and no write may appear.
         bus.load_valid_i = 1'b1;
         rdy_seen = 0;
         repeat (10) begin
            @(negedge clk_i);
            if (bus.load_ready_o) rdy_seen++;
         end
         bus.load_valid_i = 1'b0;
         chk("err_ready_cycles", rdy_seen, 32'h0);
      end
      pulse_start();
      repeat (3) @(negedge clk_i);
      chk("term_state", {28'h0, cpu_rst_o, busy_o, done_o, error_o},
          {28'h0, expect_err, 1'b0, !expect_err, expect_err});
      chk("term_wr", {28'h0, bus.mem_d_wr_o}, 32'h0);
      exp_q.delete();
   endtask

   initial begin
      #500000;
      n_cmp++;
      n_bad++;
      $display("FAIL watchdog: simulation still running, required completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.load_start_i = 1'b0;
      bus.load_valid_i = 1'b0;
      bus.load_data_i  = 8'h0;
      repeat (2) @(posedge clk_i);
      #1;
      reset_checks();
      rst_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;

      run_load(-1, 1'b0, 1'b0, 1'b0);
      do_reset();
      run_load(-1, 1'b0, 1'b1, 1'b1);
      do_reset();
      run_load(-1, 1'b1, 1'b0, 1'b0);
      do_reset();
      run_load(0, 1'b0, 1'b0, 1'b0);

      // Abort a load after two bytes; the next load must start from scratch.
      do_reset();
      pulse_start();
      send_byte(8'hAA);
      send_byte(8'hBB);
      do_reset();
      run_load(-1, 1'b0, 1'b0, 1'b0);

      stray_en = 1'b1;
      for (int k = 0; k < 6; k++) begin
         do_reset();
         run_load(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, WORDS - 1)) : -1,
                  1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
